// File: rtl/rx_pattern_checker.sv
// Loopback checker for the 16-bit source test stream: predicts each word from the
// previous valid word, tracks lock with hysteresis and counts errors while locked.
module rx_pattern_checker #(
  parameter logic [15:0] CONST_PATTERN = 16'h5A5A,
  parameter int unsigned LOCK_CNT      = 16,
  parameter int unsigned UNLOCK_CNT    = 4,
  parameter logic [31:0] ERR_CNT_RST   = '0
) (
  input  logic        clk1280,
  input  logic        rst,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  input  logic [1:0]  sel,
  input  logic        clr_err,
  output logic        locked,
  output logic        err_pulse,
  output logic [31:0] err_cnt
);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

  localparam logic [7:0] LOCK_THR   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_THR = 8'(UNLOCK_CNT);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_sel;
  logic        w_sel_chg;
  logic [15:0] r_hist;
  logic        r_hist_vld;
  logic [15:0] r_s1_data, r_s1_exp;
  logic        r_s1_vld;
  logic        r_s2_vld, r_s2_miss;
  logic [7:0]  r_match_cnt, r_miss_cnt, w_match_nxt, w_miss_nxt;
  logic [31:0] r_err_cnt, w_err_nxt;
  logic        r_err_pulse, w_err_pulse_nxt;
  logic [31:0] w_prbs;
  logic [15:0] w_exp;

  assign w_sel_chg = (sel != r_sel);

  // PRBS: bits [31:16] hold the previous word (bit 31 earliest); each new bit is
  // the XOR of the bits 14 and 15 positions earlier, filled in earliest-first.
  always_comb begin
    w_prbs = {r_hist, 16'h0000};
    for (int unsigned i = 0; i < 16; i++) begin
      w_prbs[15-i] = w_prbs[29-i] ^ w_prbs[30-i];
    end
    unique case (sel)
      2'd0:    w_exp = r_hist + 16'd1;
      2'd1:    w_exp = w_prbs[15:0];
      2'd2:    w_exp = CONST_PATTERN;
      default: w_exp = ~CONST_PATTERN;
    endcase
  end

  always_ff @(posedge clk1280 or posedge rst) begin
    if (rst) begin
      r_sel      <= '0;
      r_hist     <= '0;
      r_hist_vld <= 1'b0;
      r_s1_data  <= '0;
      r_s1_exp   <= '0;
      r_s1_vld   <= 1'b0;
      r_s2_vld   <= 1'b0;
      r_s2_miss  <= 1'b0;
    end else begin
      r_sel    <= sel;
      // A word arriving with a select change only seeds history.
      r_s1_vld <= rx_valid & r_hist_vld & ~w_sel_chg;
      if (rx_valid) begin
        r_hist     <= rx_data;
        r_hist_vld <= 1'b1;
        r_s1_data  <= rx_data;
        r_s1_exp   <= w_exp;
      end else if (w_sel_chg) begin
        r_hist_vld <= 1'b0;
      end
      r_s2_vld  <= r_s1_vld & ~w_sel_chg;
      r_s2_miss <= (r_s1_data != r_s1_exp);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_match_nxt     = r_match_cnt;
    w_miss_nxt      = r_miss_cnt;
    w_err_nxt       = r_err_cnt;
    w_err_pulse_nxt = 1'b0;
    if (w_sel_chg) begin
      w_state_nxt = ST_UNLOCKED;
      w_match_nxt = '0;
      w_miss_nxt  = '0;
    end else if (r_s2_vld) begin
      unique case (r_state)
        ST_UNLOCKED: begin
          if (r_s2_miss) begin
            w_match_nxt = '0;
          end else if (r_match_cnt + 8'd1 == LOCK_THR) begin
            w_state_nxt = ST_LOCKED;
            w_match_nxt = '0;
          end else begin
            w_match_nxt = r_match_cnt + 8'd1;
          end
        end
        default: begin
          if (r_s2_miss) begin
            w_err_pulse_nxt = 1'b1;
            if (r_err_cnt != '1) w_err_nxt = r_err_cnt + 32'd1;
            if (r_miss_cnt + 8'd1 == UNLOCK_THR) begin
              w_state_nxt = ST_UNLOCKED;
              w_match_nxt = '0;
              w_miss_nxt  = '0;
            end else begin
              w_miss_nxt = r_miss_cnt + 8'd1;
            end
          end else begin
            w_miss_nxt = '0;
          end
        end
      endcase
    end
    if (clr_err) w_err_nxt = '0;
  end

  always_ff @(posedge clk1280 or posedge rst) begin
    if (rst) begin
      r_state     <= ST_UNLOCKED;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_err_cnt   <= ERR_CNT_RST;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
      r_err_cnt   <= w_err_nxt;
      r_err_pulse <= w_err_pulse_nxt;
    end
  end

  assign locked    = (r_state == ST_LOCKED);
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_rx_pattern_checker.sv
// Bench for rx_pattern_checker: vector tables, directed corner sequences and a
// randomized stream checked every cycle against a word-level reference model.
module tb_rx_pattern_checker;

  localparam logic [15:0] CPAT   = 16'h5A5A;
  localparam int          LOCK   = 16;
  localparam int          UNLOCK = 4;

  logic        clk = 1'b0;
  logic        rst, rx_valid, clr_err, locked, err_pulse;
  logic [15:0] rx_data;
  logic [1:0]  sel;
  logic [31:0] err_cnt;

  logic        s_rst, s_valid, s_clr, s_locked, s_pulse;
  logic [15:0] s_data;
  logic [1:0]  s_sel;
  logic [31:0] s_cnt;

  always #5 clk = ~clk;

  rx_pattern_checker #(.CONST_PATTERN(CPAT), .LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK)) dut (
    .clk1280(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .sel(sel),
    .clr_err(clr_err), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt));

  // Second instance preloads the error counter so saturation is reachable quickly.
  rx_pattern_checker #(.CONST_PATTERN(CPAT), .LOCK_CNT(2), .UNLOCK_CNT(255),
                       .ERR_CNT_RST(32'hFFFF_FFFD)) dut_sat (
    .clk1280(clk), .rst(s_rst), .rx_data(s_data), .rx_valid(s_valid), .sel(s_sel),
    .clr_err(s_clr), .locked(s_locked), .err_pulse(s_pulse), .err_cnt(s_cnt));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Next word of each pattern given the previous word; PRBS built as a bit sequence.
  function automatic logic [15:0] exp_word(input logic [1:0] s, input logic [15:0] p);
    logic        bits [0:31];
    logic [15:0] w;
    w = '0;
    case (s)
      2'd0: return p + 16'd1;
      2'd2: return CPAT;
      2'd3: return ~CPAT;
      default: ;
    endcase
    for (int j = 0; j < 16; j++) bits[j] = p[15-j];
    for (int n = 16; n < 32; n++) bits[n] = bits[n-14] ^ bits[n-15];
    for (int j = 0; j < 16; j++) w[15-j] = bits[16+j];
    return w;
  endfunction

  // Reference model: word outcomes queued with a due cycle two edges later.
  typedef struct { int due; bit miss; } pend_t;
  pend_t       pend[$];
  int          cyc = 0;
  logic [1:0]  m_sel;
  bit          m_hv, m_locked, m_pulse;
  logic [15:0] m_prev;
  int          m_match, m_miss;
  logic [31:0] m_cnt;

  task automatic model_reset();
    pend.delete();
    m_sel = 2'd0; m_hv = 0; m_locked = 0; m_pulse = 0;
    m_prev = '0; m_match = 0; m_miss = 0; m_cnt = '0;
  endtask

  task automatic model_edge(input logic v, input logic [15:0] d, input logic [1:0] s, input logic c);
    bit mis;
    m_pulse = 0;
    if (s != m_sel) begin
      m_sel = s; pend.delete();
      m_locked = 0; m_match = 0; m_miss = 0;
      m_hv = v;
      if (v) m_prev = d;
    end else begin
      if (pend.size() > 0 && pend[0].due == cyc) begin
        mis = pend[0].miss;
        void'(pend.pop_front());
        if (!m_locked) begin
          if (mis) m_match = 0;
          else begin
            m_match++;
            if (m_match == LOCK) begin m_locked = 1; m_match = 0; end
          end
        end else if (mis) begin
          m_pulse = 1;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
          m_miss++;
          if (m_miss == UNLOCK) begin m_locked = 0; m_miss = 0; m_match = 0; end
        end else m_miss = 0;
      end
      if (v) begin
        if (m_hv) pend.push_back('{cyc + 2, d != exp_word(s, m_prev)});
        m_prev = d; m_hv = 1;
      end
    end
    if (c) m_cnt = '0;
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic [1:0] s, input logic c);
    rx_valid = v; rx_data = d; sel = s; clr_err = c;
    @(posedge clk); #1;
    cyc++;
    model_edge(v, d, s, c);
    chk("locked", {31'd0, locked}, {31'd0, m_locked});
    chk("err_pulse", {31'd0, err_pulse}, {31'd0, m_pulse});
    chk("err_cnt", err_cnt, m_cnt);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_locked", {31'd0, locked}, 32'd0);
    chk("async_rst_pulse", {31'd0, err_pulse}, 32'd0);
    chk("async_rst_err_cnt", err_cnt, 32'd0);
    @(negedge clk); rst = 1'b0;
  endtask

  typedef struct {
    int          rep;
    logic        v;
    logic [15:0] d;
    logic [1:0]  s;
    logic        c;
    logic        el;
    logic        ep;
    logic [31:0] ec;
  } vec_t;

  vec_t tbl [16];
  vec_t stbl [9];

  initial begin
    logic [15:0] tx, w, bad;
    logic [1:0]  cur;
    logic        v, c, e2;
    logic [15:0] d;

    tbl = '{
      '{17, 1'b1, 16'h5A5A, 2'd2, 1'b0, 1'b0, 1'b0, 32'd0},
      '{ 2, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b1, 1'b0, 32'd0},
      '{ 4, 1'b1, 16'h0000, 2'd2, 1'b0, 1'b1, 1'b1, 32'd2},
      '{ 1, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b1, 1'b1, 32'd3},
      '{ 1, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0, 1'b1, 32'd4},
      '{ 1, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b0, 1'b0, 32'd4},
      '{16, 1'b1, 16'h5A5A, 2'd2, 1'b0, 1'b0, 1'b0, 32'd4},
      '{ 2, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b1, 1'b0, 32'd4},
      '{ 1, 1'b0, 16'h0000, 2'd2, 1'b1, 1'b1, 1'b0, 32'd0},
      '{ 1, 1'b1, 16'hA5A5, 2'd3, 1'b0, 1'b0, 1'b0, 32'd0},
      '{16, 1'b1, 16'hA5A5, 2'd3, 1'b0, 1'b0, 1'b0, 32'd0},
      '{ 2, 1'b0, 16'h0000, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0},
      '{ 1, 1'b1, 16'h5A5A, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0},
      '{ 1, 1'b0, 16'h0000, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0},
      '{ 1, 1'b0, 16'h0000, 2'd3, 1'b0, 1'b1, 1'b1, 32'd1},
      '{ 1, 1'b0, 16'h0000, 2'd3, 1'b0, 1'b1, 1'b0, 32'd1}
    };
    stbl = '{
      '{3, 1'b1, 16'h5A5A, 2'd2, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFD},
      '{3, 1'b1, 16'h0000, 2'd2, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE},
      '{1, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF},
      '{1, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF},
      '{1, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF},
      '{1, 1'b1, 16'h0000, 2'd2, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF},
      '{1, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF},
      '{1, 1'b0, 16'h0000, 2'd2, 1'b1, 1'b1, 1'b1, 32'd0},
      '{1, 1'b0, 16'h0000, 2'd2, 1'b0, 1'b1, 1'b0, 32'd0}
    };

    rst = 1'b1; s_rst = 1'b1;
    rx_valid = 1'b0; rx_data = '0; sel = 2'd0; clr_err = 1'b0;
    s_valid = 1'b0; s_data = '0; s_sel = 2'd2; s_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_pulse", {31'd0, err_pulse}, 32'd0);
    chk("rst_err_cnt", err_cnt, 32'd0);
    chk("sat_rst_locked", {31'd0, s_locked}, 32'd0);
    chk("sat_rst_err_cnt", s_cnt, 32'hFFFF_FFFD);
    @(negedge clk); rst = 1'b0; s_rst = 1'b0;

    // Saturation and clear-vs-increment on the preloaded instance.
    for (int r = 0; r < 9; r++) begin
      for (int k = 0; k < stbl[r].rep; k++) begin
        s_valid = stbl[r].v; s_data = stbl[r].d; s_sel = stbl[r].s; s_clr = stbl[r].c;
        step(1'b0, 16'h0000, 2'd0, 1'b0);
      end
      chk($sformatf("sat_row%0d_locked", r), {31'd0, s_locked}, {31'd0, stbl[r].el});
      chk($sformatf("sat_row%0d_pulse", r), {31'd0, s_pulse}, {31'd0, stbl[r].ep});
      chk($sformatf("sat_row%0d_cnt", r), s_cnt, stbl[r].ec);
    end
    s_valid = 1'b0; s_clr = 1'b0;

    // Constant lock, unlock, relock, clear, select change and relock.
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < tbl[r].rep; k++) step(tbl[r].v, tbl[r].d, tbl[r].s, tbl[r].c);
      chk($sformatf("tbl_row%0d_locked", r), {31'd0, locked}, {31'd0, tbl[r].el});
      chk($sformatf("tbl_row%0d_pulse", r), {31'd0, err_pulse}, {31'd0, tbl[r].ep});
      chk($sformatf("tbl_row%0d_cnt", r), err_cnt, tbl[r].ec);
    end

    // Counter lock across the 16'hFFFF wrap.
    sel = 2'd0;
    async_reset();
    tx = 16'hFFF0;
    for (int i = 0; i < 17; i++) begin step(1'b1, tx, 2'd0, 1'b0); tx++; end
    step(1'b1, tx, 2'd0, 1'b0); tx++;
    chk("cnt_lock_early", {31'd0, locked}, 32'd0);
    step(1'b1, tx, 2'd0, 1'b0); tx++;
    chk("cnt_lock", {31'd0, locked}, 32'd1);
    chk("cnt_wrap_err", err_cnt, 32'd0);

    // Valid gaps with junk data on idle cycles.
    for (int i = 0; i < 60; i++) begin
      v = 1'($urandom_range(1));
      step(v, v ? tx : 16'($urandom), 2'd0, 1'b0);
      if (v) tx++;
    end
    step(1'b0, 16'h0000, 2'd0, 1'b0);
    step(1'b0, 16'h0000, 2'd0, 1'b0);
    chk("gap_locked", {31'd0, locked}, 32'd1);
    chk("gap_err_cnt", err_cnt, 32'd0);

    // One corrupted counter word costs two compares (itself and its successor).
    step(1'b1, tx ^ 16'h0100, 2'd0, 1'b0); tx++;
    for (int i = 0; i < 3; i++) begin step(1'b1, tx, 2'd0, 1'b0); tx++; end
    chk("cnt_inj_err_cnt", err_cnt, 32'd2);
    chk("cnt_inj_locked", {31'd0, locked}, 32'd1);

    async_reset();
    for (int i = 0; i < 17; i++) begin step(1'b1, tx, 2'd0, 1'b0); tx++; end
    step(1'b1, tx, 2'd0, 1'b0); tx++;
    step(1'b1, tx, 2'd0, 1'b0); tx++;
    chk("relock_after_rst", {31'd0, locked}, 32'd1);

    // PRBS lock, then flip bit 0 of a single word.
    w = 16'hACE1;
    step(1'b1, w, 2'd1, 1'b0);
    for (int i = 0; i < 18; i++) begin w = exp_word(2'd1, w); step(1'b1, w, 2'd1, 1'b0); end
    step(1'b0, 16'h0000, 2'd1, 1'b0);
    step(1'b0, 16'h0000, 2'd1, 1'b0);
    chk("prbs_lock", {31'd0, locked}, 32'd1);
    chk("prbs_clean_err", err_cnt, 32'd0);
    w = exp_word(2'd1, w); bad = w ^ 16'h0001;
    step(1'b1, bad, 2'd1, 1'b0);
    w = exp_word(2'd1, w);
    e2 = (w != exp_word(2'd1, bad));
    step(1'b1, w, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin w = exp_word(2'd1, w); step(1'b1, w, 2'd1, 1'b0); end
    chk("prbs_err_cnt", err_cnt, 32'd1 + {31'd0, e2});
    chk("prbs_still_locked", {31'd0, locked}, 32'd1);

    // Randomized traffic: rare select changes, corruption, clears and gaps.
    cur = 2'd1; tx = w;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(149) == 0) cur = 2'($urandom_range(3));
      v = ($urandom_range(3) != 0);
      d = exp_word(cur, tx);
      if (v) tx = d;
      if ($urandom_range(31) == 0) d = d ^ (16'd1 << $urandom_range(15));
      c = ($urandom_range(59) == 0);
      step(v, d, cur, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
